// File: rtl/cache_axi_arbiter_pkg.sv
// cache_axi_arbiter_pkg: shared types, owner encodings and line-address helpers for the cache AXI arbiter
package cache_axi_arbiter_pkg;
  typedef enum logic [2:0] {LT_W, LT_B, LT_H, LT_BU, LT_HU} LoadType;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_t;
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_I = 2'd0;
  localparam owner_t OWN_D = 2'd1;
  localparam owner_t OWN_U = 2'd2;
  localparam int LINE_ADDR_MSB = 31;
  localparam int LINE_ADDR_LSB = 4;
  function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
    return a[LINE_ADDR_MSB:LINE_ADDR_LSB] == b[LINE_ADDR_MSB:LINE_ADDR_LSB];
  endfunction
endpackage

// File: rtl/cache_axi_arbiter_fixed_prio_grant.sv
// fixed_prio_grant: one-hot picker, bit 0 has highest priority
module fixed_prio_grant #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  assign gnt_o = req_i & (~req_i + N'(1));
endmodule

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one downstream read/write request port between icache, dcache and uncached port
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ic_rd_req_i,
  input  logic [31:0]   ic_rd_addr_i,
  output logic          ic_rd_rdy_o,
  output logic          ic_ret_valid_o,
  output logic [127:0]  ic_ret_data_o,
  output logic          ic_wr_rdy_o,
  output logic          ic_wr_valid_o,
  input  logic          dc_rd_req_i,
  input  logic [31:0]   dc_rd_addr_i,
  output logic          dc_rd_rdy_o,
  output logic          dc_ret_valid_o,
  output logic [127:0]  dc_ret_data_o,
  input  logic          dc_wr_req_i,
  input  logic [31:0]   dc_wr_addr_i,
  input  logic [127:0]  dc_wr_data_i,
  output logic          dc_wr_rdy_o,
  output logic          dc_wr_valid_o,
  input  logic          uc_rd_req_i,
  input  logic [31:0]   uc_rd_addr_i,
  input  LoadType       uc_rd_loadtype_i,
  output logic          uc_rd_rdy_o,
  output logic          uc_ret_valid_o,
  output logic [31:0]   uc_ret_data_o,
  input  logic          uc_wr_req_i,
  input  logic [31:0]   uc_wr_addr_i,
  input  logic [31:0]   uc_wr_data_i,
  input  logic [3:0]    uc_wr_wstrb_i,
  output logic          uc_wr_rdy_o,
  output logic          uc_wr_valid_o,
  output logic          m_rd_req_o,
  output logic [31:0]   m_rd_addr_o,
  output logic          m_rd_line_o,
  output LoadType       m_rd_loadtype_o,
  input  logic          m_rd_rdy_i,
  input  logic          m_ret_valid_i,
  input  logic [127:0]  m_ret_data_i,
  output logic          m_wr_req_o,
  output logic [31:0]   m_wr_addr_o,
  output logic [127:0]  m_wr_data_o,
  output logic [3:0]    m_wr_strb_o,
  output logic          m_wr_line_o,
  input  logic          m_wr_rdy_i,
  input  logic          m_wr_valid_i
);
  rd_state_t    rd_state_q, rd_state_d;
  wr_state_t    wr_state_q, wr_state_d;
  owner_t       rd_own_q, rd_own_d, wr_own_q, wr_own_d;
  logic [31:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic         rd_line_q, rd_line_d, wr_line_q, wr_line_d;
  LoadType      rd_lt_q, rd_lt_d;
  logic [127:0] wr_data_q, wr_data_d;
  logic [3:0]   wr_strb_q, wr_strb_d;
  logic [2:0]   rd_elig, rd_gnt;
  logic [1:0]   wr_elig, wr_gnt;
  logic         dc_haz, uc_haz, rd_done, wr_done;
  assign wr_elig = (wr_state_q == W_IDLE && !rst) ? {uc_wr_req_i, dc_wr_req_i} : 2'b00;
  fixed_prio_grant #(.N(2)) u_wr_gnt (.req_i(wr_elig), .gnt_o(wr_gnt));
  assign dc_haz = (wr_state_q != W_IDLE && wr_own_q == OWN_D && same_line(wr_addr_q, dc_rd_addr_i))
                || (wr_gnt[0] && same_line(dc_wr_addr_i, dc_rd_addr_i));
  assign uc_haz = (wr_state_q != W_IDLE && wr_own_q == OWN_U) || wr_gnt[1];
  assign rd_elig = (rd_state_q == R_IDLE && !rst) ? {ic_rd_req_i, dc_rd_req_i & ~dc_haz, uc_rd_req_i & ~uc_haz} : 3'b000;
  fixed_prio_grant #(.N(3)) u_rd_gnt (.req_i(rd_elig), .gnt_o(rd_gnt));
  assign rd_done = rd_state_q == R_WAIT && m_ret_valid_i && !rst;
  assign wr_done = wr_state_q == W_WAIT && m_wr_valid_i && !rst;
  assign uc_rd_rdy_o = rd_gnt[0];
  assign dc_rd_rdy_o = rd_gnt[1];
  assign ic_rd_rdy_o = rd_gnt[2];
  assign dc_wr_rdy_o = wr_gnt[0];
  assign uc_wr_rdy_o = wr_gnt[1];
  assign ic_wr_rdy_o = 1'b0;
  assign ic_wr_valid_o = 1'b0;
  assign ic_ret_valid_o = rd_done && rd_own_q == OWN_I;
  assign dc_ret_valid_o = rd_done && rd_own_q == OWN_D;
  assign uc_ret_valid_o = rd_done && rd_own_q == OWN_U;
  assign ic_ret_data_o = ic_ret_valid_o ? m_ret_data_i : '0;
  assign dc_ret_data_o = dc_ret_valid_o ? m_ret_data_i : '0;
  assign uc_ret_data_o = uc_ret_valid_o ? m_ret_data_i[31:0] : '0;
  assign dc_wr_valid_o = wr_done && wr_own_q == OWN_D;
  assign uc_wr_valid_o = wr_done && wr_own_q == OWN_U;
  assign m_rd_req_o = rd_state_q == R_REQ;
  assign m_rd_addr_o = rd_addr_q;
  assign m_rd_line_o = rd_line_q;
  assign m_rd_loadtype_o = rd_lt_q;
  assign m_wr_req_o = wr_state_q == W_REQ;
  assign m_wr_addr_o = wr_addr_q;
  assign m_wr_data_o = wr_data_q;
  assign m_wr_strb_o = wr_strb_q;
  assign m_wr_line_o = wr_line_q;
  // read FSM next state: latch the winner in idle, then handshake, then wait for return
  always_comb begin
    rd_state_d = rd_state_q;
    rd_own_d = rd_own_q;
    rd_addr_d = rd_addr_q;
    rd_line_d = rd_line_q;
    rd_lt_d = rd_lt_q;
    if (|rd_gnt) begin
      rd_state_d = R_REQ;
      rd_own_d = rd_gnt[0] ? OWN_U : rd_gnt[1] ? OWN_D : OWN_I;
      rd_addr_d = rd_gnt[0] ? uc_rd_addr_i : rd_gnt[1] ? dc_rd_addr_i : ic_rd_addr_i;
      rd_line_d = !rd_gnt[0];
      rd_lt_d = rd_gnt[0] ? uc_rd_loadtype_i : LT_W;
    end else if (rd_state_q == R_REQ && m_rd_rdy_i) begin
      rd_state_d = R_WAIT;
    end else if (rd_done) begin
      rd_state_d = R_IDLE;
    end
  end
  // write FSM next state: dcache writes whole lines, uncache writes one strobed word
  always_comb begin
    wr_state_d = wr_state_q;
    wr_own_d = wr_own_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    wr_line_d = wr_line_q;
    if (|wr_gnt) begin
      wr_state_d = W_REQ;
      wr_own_d = wr_gnt[0] ? OWN_D : OWN_U;
      wr_addr_d = wr_gnt[0] ? dc_wr_addr_i : uc_wr_addr_i;
      wr_data_d = wr_gnt[0] ? dc_wr_data_i : {96'b0, uc_wr_data_i};
      wr_strb_d = wr_gnt[0] ? 4'hF : uc_wr_wstrb_i;
      wr_line_d = wr_gnt[0];
    end else if (wr_state_q == W_REQ && m_wr_rdy_i) begin
      wr_state_d = W_WAIT;
    end else if (wr_done) begin
      wr_state_d = W_IDLE;
    end
  end
  // state and latched request fields; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rd_own_q <= OWN_I;
      wr_own_q <= OWN_I;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_line_q <= 1'b0;
      wr_line_q <= 1'b0;
      rd_lt_q <= LT_W;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_own_q <= rd_own_d;
      wr_own_q <= wr_own_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_line_q <= rd_line_d;
      wr_line_q <= wr_line_d;
      rd_lt_q <= rd_lt_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end
endmodule
